// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand forwarding and hazard control beside IDU.
// - Forwards from NFWD producer stages (index 0 = youngest), youngest wins.
// - Detects load-use hazards (matching stage result not yet ready).
// - Keeps a busy scoreboard for out-of-pipe long-latency ops, with a
//   same-cycle completion bypass and WAW protection on issue.
// Optional stall counters are built when FWD_PERF_CNT_EN is defined;
// otherwise the perf ports are tied to zero and no counter flops exist.
module fwd_hazard_ctrl #(
    parameter int XLEN = 64,
    parameter int NFWD = 3,
    parameter int RAW  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   idu_valid,
    input  logic                   idu_use_rs1,
    input  logic                   idu_use_rs2,
    input  logic [RAW-1:0]         idu_index_rs1,
    input  logic [RAW-1:0]         idu_index_rs2,
    input  logic [NFWD-1:0]        stg_wb_en,
    input  logic [NFWD*RAW-1:0]    stg_index_rd,
    input  logic [NFWD-1:0]        stg_data_rdy,
    input  logic [NFWD*XLEN-1:0]   stg_data,
    input  logic                   lat_issue,
    input  logic [RAW-1:0]         lat_issue_rd,
    input  logic                   lat_done,
    input  logic [RAW-1:0]         lat_done_rd,
    input  logic [XLEN-1:0]        lat_done_data,
    input  logic                   lat_kill,
    output logic                   fw_en1,
    output logic                   fw_en2,
    output logic [XLEN-1:0]        fw_data1,
    output logic [XLEN-1:0]        fw_data2,
    output logic                   stall,
    output logic [(1<<RAW)-1:0]    sb_busy,
    output logic                   sb_err,
    output logic [31:0]            perf_stall_lu,
    output logic [31:0]            perf_stall_sb
);

    localparam int NREG = 1 << RAW;

    logic [NREG-1:0] sb_busy_q, sb_busy_d;
    logic            sb_err_q, sb_err_d;

    logic            hit1, hit2, rdy1, rdy2;
    logic [XLEN-1:0] sdata1, sdata2;
    logic            byp1, byp2, sbh1, sbh2, lu1, lu2, waw;
    logic            stall_lu, stall_sb;

    // Stage match per operand: scan oldest to youngest so the youngest match overrides.
    always_comb begin
        hit1   = 1'b0;
        rdy1   = 1'b0;
        sdata1 = '0;
        hit2   = 1'b0;
        rdy2   = 1'b0;
        sdata2 = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (idu_use_rs1 && stg_wb_en[i] && (stg_index_rd[i*RAW +: RAW] != '0) &&
                (stg_index_rd[i*RAW +: RAW] == idu_index_rs1)) begin
                hit1   = 1'b1;
                rdy1   = stg_data_rdy[i];
                sdata1 = stg_data[i*XLEN +: XLEN];
            end
            if (idu_use_rs2 && stg_wb_en[i] && (stg_index_rd[i*RAW +: RAW] != '0) &&
                (stg_index_rd[i*RAW +: RAW] == idu_index_rs2)) begin
                hit2   = 1'b1;
                rdy2   = stg_data_rdy[i];
                sdata2 = stg_data[i*XLEN +: XLEN];
            end
        end
    end

    // Completion bypass, scoreboard hazards, output muxing and the IDU stall.
    always_comb begin
        byp1 = !hit1 && idu_use_rs1 && lat_done && (lat_done_rd == idu_index_rs1) &&
               (idu_index_rs1 != '0);
        byp2 = !hit2 && idu_use_rs2 && lat_done && (lat_done_rd == idu_index_rs2) &&
               (idu_index_rs2 != '0);
        sbh1 = !hit1 && idu_use_rs1 && sb_busy_q[idu_index_rs1] && !byp1;
        sbh2 = !hit2 && idu_use_rs2 && sb_busy_q[idu_index_rs2] && !byp2;
        lu1  = hit1 && !rdy1;
        lu2  = hit2 && !rdy2;
        // A re-issue to a busy rd must wait unless that rd completes this cycle.
        waw  = lat_issue && sb_busy_q[lat_issue_rd] &&
               !(lat_done && (lat_done_rd == lat_issue_rd));

        stall_lu = lu1 || lu2;
        stall_sb = sbh1 || sbh2 || waw;
        stall    = idu_valid && (stall_lu || stall_sb);

        fw_en1   = (hit1 && rdy1) || byp1;
        fw_en2   = (hit2 && rdy2) || byp2;
        fw_data1 = (hit1 && rdy1) ? sdata1 : (byp1 ? lat_done_data : '0);
        fw_data2 = (hit2 && rdy2) ? sdata2 : (byp2 ? lat_done_data : '0);
    end

    // Scoreboard next state: kill dominates; an issue overrides a done to the same rd.
    always_comb begin
        sb_busy_d = sb_busy_q;
        if (lat_kill) begin
            sb_busy_d = '0;
        end else begin
            if (lat_done) begin
                sb_busy_d[lat_done_rd] = 1'b0;
            end
            if (lat_issue && (lat_issue_rd != '0)) begin
                sb_busy_d[lat_issue_rd] = 1'b1;
            end
        end
        sb_err_d = sb_err_q || (lat_done && !sb_busy_q[lat_done_rd]) ||
                   (lat_issue && stall);
    end

    // Scoreboard and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_busy_q <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            sb_busy_q <= sb_busy_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign sb_busy = sb_busy_q;
    assign sb_err  = sb_err_q;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_lu_q, perf_lu_d, perf_sb_q, perf_sb_d;

    // Saturating stall counters; a cycle with both causes is charged to load-use.
    always_comb begin
        perf_lu_d = perf_lu_q;
        perf_sb_d = perf_sb_q;
        if (idu_valid && stall_lu && (perf_lu_q != 32'hFFFF_FFFF)) begin
            perf_lu_d = perf_lu_q + 32'd1;
        end
        if (idu_valid && stall_sb && !stall_lu && (perf_sb_q != 32'hFFFF_FFFF)) begin
            perf_sb_d = perf_sb_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_q <= '0;
            perf_sb_q <= '0;
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_sb_q <= perf_sb_d;
        end
    end

    assign perf_stall_lu = perf_lu_q;
    assign perf_stall_sb = perf_sb_q;
`else
    assign perf_stall_lu = 32'd0;
    assign perf_stall_sb = 32'd0;
`endif

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Parametrised forwarding and hazard controller for the NPC pipeline, sitting beside IDU.
- Generalises two-stage EX/MEM forwarding to NFWD producer stages with youngest-wins priority.
- Adds load-use stall detection.
- Adds a register scoreboard for the long-latency MUL/DIV unit that issues out of the main pipe, with a completion bypass.
- Produces per-operand forward enables/data and one IDU stall.

Parameters:
XLEN, 64, datapath width
NFWD, 3, producer stages checked; index 0 = youngest (EX), then MEM, WB
RAW, 5, register index width (2**RAW architectural registers)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
idu_valid  in  1  IDU holds a valid instruction
idu_use_rs1 / idu_use_rs2  in  1 each  operand actually read
idu_index_rs1 / idu_index_rs2  in  RAW each  source indices
stg_wb_en  in  NFWD  stage i writes a register
stg_index_rd  in  NFWD*RAW  stage i destination; slice i = [i*RAW +: RAW]
stg_data_rdy  in  NFWD  stage i result valid (0 = load still in flight)
stg_data  in  NFWD*XLEN  stage i result
lat_issue  in  1  long-latency op leaves IDU this cycle
lat_issue_rd  in  RAW  its destination
lat_done  in  1  long-latency result completes this cycle
lat_done_rd  in  RAW  completing destination
lat_done_data  in  XLEN  completing result
lat_kill  in  1  abort all in-flight long-latency ops
fw_en1 / fw_en2  out  1 each  operand forwarded
fw_data1 / fw_data2  out  XLEN each  forwarded value, 0 when not forwarding
stall  out  1  hold IDU/IFU, insert bubble into EXU
sb_busy  out  2**RAW  registered scoreboard vector
sb_err  out  1  sticky protocol error
perf_stall_lu / perf_stall_sb  out  32 each  stall counters (see Optional Feature)

Behaviour:
Reset values (async, while rst=1):
- sb_busy=0, sb_err=0, perf counters=0.
- Combinational outputs settle to fw_en=0, fw_data=0, stall=0 when no stage or scoreboard matches.

Match rules, per operand:
- Operand k matches stage i when idu_use_rsk & stg_wb_en[i] & rd_i!=0 & rd_i==rsk.
- The lowest matching i wins. Older matches are ignored.

Forward/stall per operand:
- Winner has stg_data_rdy=1: fw_en=1, fw_data=stg_data[i].
- Winner has stg_data_rdy=0: load-use hazard. fw_en=0, data=0, contributes stall_lu.
- No stage match, lat_done=1 and lat_done_rd==rsk!=0: fw_en=1, fw_data=lat_done_data (completion bypass, same cycle).
- No stage match, sb_busy[rsk]=1 and no completion bypass: contributes stall_sb.

Stall conditions:
- WAW: lat_issue with sb_busy[lat_issue_rd]=1 and no same-cycle lat_done to that rd. Contributes stall_sb. IDU must not assert lat_issue while stall=1.
- stall = idu_valid & (stall_lu | stall_sb). It is purely combinational; zero-cycle latency.

Scoreboard update (registered, next edge), priority highest first:
- lat_kill clears all bits. Issue/done in the same cycle are ignored.
- lat_issue & rd!=0 sets bit rd.
- lat_done clears bit lat_done_rd, unless the same rd is issued in the same cycle, in which case the bit stays 1.
- Bit 0 is never set.

sb_err:
- Set on lat_done to a non-busy register, or lat_issue while stall=1.
- Cleared only by rst.

Reset mid-operation: all busy bits drop immediately. Any completion arriving after reset sets sb_err (bench must not do this unless testing it).

Optional Feature:
Macro FWD_PERF_CNT_EN.
- Defined: perf_stall_lu increments every cycle with idu_valid & stall_lu. perf_stall_sb increments every cycle with idu_valid & stall_sb & !stall_lu. Both saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: no counter flops. Both ports tied to 0. Functional behaviour is otherwise identical.

Test Plan:
1. EX rd=5 data=0x11 rdy, MEM rd=5 data=0x22, IDU rs1=5 -> fw_en1=1, fw_data1=0x11, stall=0.
2. EX rd=7 wb_en, rdy=0 (load), IDU rs2=7 use_rs2=1 -> stall=1, fw_en2=0; next cycle bubble in EX, MEM rd=7 rdy data=0xABCD -> fw_data2=0xABCD, stall=0.
3. rd=0 in all stages with nonzero data, rs1=rs2=0 -> fw_en1=fw_en2=0, data 0, stall=0.
4. lat_issue rd=9; next cycles IDU rs1=9 -> stall=1, sb_busy[9]=1; lat_done rd=9 data=0x55 -> same cycle fw_en1=1, fw_data1=0x55, stall=0; next cycle sb_busy[9]=0.
5. sb_busy[3]=1, same cycle lat_done rd=3 and lat_issue rd=3 -> sb_busy[3] stays 1, sb_err=0; then lat_kill -> sb_busy=0; then lat_done rd=4 -> sb_err=1 (sticky).
6. With FWD_PERF_CNT_EN: 4 load-use cycles + 3 scoreboard cycles -> perf_stall_lu=4, perf_stall_sb=3; assert rst mid-stall -> all zero immediately.
